masked_sbox_lookup_ctrl: RTL and testbench
==========================================

MASKED_SBOX_LOOKUP_CTRL -- requirements
Module: masked_sbox_lookup_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, width of the BRAM address per port.
REQ-002 Parameter DATA_W, default 8, width of the BRAM read data per port.
REQ-003 Parameter TAG_W, default 4, width of the request tag carried through to the response.
REQ-004 Parameter BATCH_LEN, default 16, number of lookups per batch (one per state byte).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; begins a batch.
REQ-008 req_valid  in  1  lookup request valid.
REQ-009 req_ready  out  1  lookup request accepted when req_valid && req_ready.
REQ-010 req_addr_a, req_addr_b  in  ADDR_W each  port-A and port-B table addresses.
REQ-011 req_tag  in  TAG_W  request identifier.
REQ-012 rsp_valid  out  1  response valid.
REQ-013 rsp_ready  in  1  response consumer ready.
REQ-014 rsp_doa, rsp_dob  out  DATA_W each  table outputs for ports A and B.
REQ-015 rsp_tag  out  TAG_W  tag of the request that produced the response.
REQ-016 bram_addra, bram_addrb  out  ADDR_W each  addresses to the table BRAM.
REQ-017 bram_en  out  1  BRAM port enable and output-register enable, shared by both ports.
REQ-018 bram_rst  out  1  BRAM output-register reset.
REQ-019 bram_doa, bram_dob  in  DATA_W each  registered BRAM outputs.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at batch completion.

Function
REQ-022 The block SHALL use FSM states IDLE, RUN, DRAIN and DONE.
REQ-023 FSM transitions SHALL be: IDLE->RUN on start; RUN->DRAIN on the cycle the BATCH_LEN-th request is accepted; DRAIN->DONE when no lookup is in flight; DONE->IDLE after exactly 1 cycle.
REQ-024 A start pulse outside IDLE SHALL be ignored.
REQ-025 req_ready SHALL be (state==RUN) && !stall, where stall = rsp_valid && !rsp_ready.
REQ-026 bram_en SHALL be !stall, so the whole 2-stage BRAM pipeline freezes during backpressure.
REQ-027 bram_addra and bram_addrb SHALL be driven combinationally from req_addr_a and req_addr_b.
REQ-028 The BRAM read latency is 2 enabled cycles (address latch plus output register); valid bits v1 and v2 and tags t1 and t2 SHALL shift only when bram_en=1.
REQ-029 v1 SHALL be loaded with (req_valid && req_ready), and v2 SHALL be loaded with v1.
REQ-030 rsp_valid SHALL equal v2, rsp_doa/rsp_dob SHALL equal bram_doa/bram_dob, and rsp_tag SHALL equal t2.
REQ-031 Without stall, a request accepted at cycle T SHALL produce rsp_valid at T+2.
REQ-032 Sustained throughput SHALL be 1 lookup per cycle.
REQ-033 A 5-bit issue counter SHALL count accepted requests, clear on entering RUN, and never exceed BATCH_LEN.
REQ-034 An outstanding counter (range 0..2) SHALL increment on accept and decrement on a response handshake; when both occur in the same cycle it SHALL stay unchanged.
REQ-035 During a stall, held response data SHALL remain stable and no request SHALL be accepted.
REQ-036 done SHALL be high only while in DONE.

Reset
REQ-037 While rst=1, the FSM SHALL go to IDLE and v1, v2, both counters, t1 and t2 SHALL be cleared to 0.
REQ-038 While rst=1, req_ready, rsp_valid, done and busy SHALL be 0.
REQ-039 bram_rst SHALL equal rst, so the BRAM outputs read 0 after reset.
REQ-040 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-041 Reset asserted mid-batch SHALL discard all in-flight lookups, with no response or done produced for them.

Verification
REQ-042 Bench table model (share-0 x26_x49 table): addr 0x000->0x00, 0x001->0x01, 0x002->0xFA, 0x003->0x06.
REQ-043 Scenario 1: start; request A=0x002, B=0x003, tag 5 at cycle T, rsp_ready=1 -> rsp_valid at T+2 with doa=0xFA, dob=0x06, tag=5.
REQ-044 Scenario 2: 16 back-to-back requests with rsp_ready=1 -> 16 responses on consecutive cycles in order; req_ready low after the 16th; done pulses 3 cycles after the last accept.
REQ-045 Scenario 3: rsp_ready=0 for 4 cycles while rsp_valid -> bram_en=0, req_ready=0, response held stable; on release, data resumes with no loss or duplication.
REQ-046 Scenario 4: rst asserted with 2 lookups in flight -> next cycle state IDLE, rsp_valid=0, busy=0; no done pulse.
REQ-047 Scenario 5: start during RUN -> ignored, issue count unaffected; start and rst in the same cycle -> remains IDLE.
REQ-048 Scenario 6: request valid in IDLE or DRAIN -> req_ready=0 and no response generated.

Source files
------------

// File: rtl/masked_sbox_lookup_ctrl.sv
// Request/response controller for a masked S-box table held in a dual-port BRAM
// with 2-cycle registered read latency; tracks batches of BATCH_LEN lookups.
module masked_sbox_lookup_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int TAG_W     = 4,
    parameter int BATCH_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_doa,
    output logic [DATA_W-1:0] rsp_dob,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [ADDR_W-1:0] bram_addrb,
    output logic              bram_en,
    output logic              bram_rst,
    input  logic [DATA_W-1:0] bram_doa,
    input  logic [DATA_W-1:0] bram_dob,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               stall;
    logic               accept;
    logic               rsp_hs;
    logic               last_req;
    logic               v1;
    logic               v2;
    logic [TAG_W-1:0]   t1;
    logic [TAG_W-1:0]   t2;
    logic [4:0]         issue_cnt;
    logic [1:0]         outstanding;
    logic [1:0]         outstanding_nxt;

    // Outputs are gated by rst so nothing leaks out during the reset cycle itself.
    assign stall      = rsp_valid && !rsp_ready;
    assign bram_en    = !stall;
    assign bram_rst   = rst;
    assign bram_addra = req_addr_a;
    assign bram_addrb = req_addr_b;
    assign req_ready  = !rst && (state == RUN) && !stall;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = !rst && v2;
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign rsp_doa    = bram_doa;
    assign rsp_dob    = bram_dob;
    assign rsp_tag    = t2;
    assign busy       = !rst && (state != IDLE);
    assign done       = !rst && (state == DONE);
    assign last_req   = (issue_cnt == 5'(BATCH_LEN - 1));

    always_comb begin
        outstanding_nxt = outstanding;
        if (accept && !rsp_hs) begin
            outstanding_nxt = outstanding + 2'd1;
        end else if (!accept && rsp_hs) begin
            outstanding_nxt = outstanding - 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_req) state_nxt = DRAIN;
            // Leave DRAIN as soon as the final response handshake retires the last lookup.
            DRAIN:   if (outstanding_nxt == 2'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            v1          <= 1'b0;
            v2          <= 1'b0;
            t1          <= '0;
            t2          <= '0;
            issue_cnt   <= '0;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            if (state == IDLE && start) begin
                issue_cnt <= '0;
            end else if (accept) begin
                issue_cnt <= issue_cnt + 5'd1;
            end
            // Valid/tag shadow of the BRAM address latch and output register.
            if (bram_en) begin
                v1 <= accept;
                v2 <= v1;
                t1 <= req_tag;
                t2 <= t1;
            end
        end
    end

endmodule

// File: tb/tb_masked_sbox_lookup_ctrl.sv
// Directed bench for masked_sbox_lookup_ctrl with a behavioural 2-stage BRAM table.
module tb_masked_sbox_lookup_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst, start, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [ADDR_W-1:0] req_addr_a, req_addr_b, bram_addra, bram_addrb;
    logic [TAG_W-1:0]  req_tag, rsp_tag;
    logic [DATA_W-1:0] rsp_doa, rsp_dob, bram_doa, bram_dob;
    logic              bram_en, bram_rst, busy, done;
    logic [ADDR_W-1:0] lat_a, lat_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    masked_sbox_lookup_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .BATCH_LEN(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_doa(rsp_doa), .rsp_dob(rsp_dob), .rsp_tag(rsp_tag),
        .bram_addra(bram_addra), .bram_addrb(bram_addrb),
        .bram_en(bram_en), .bram_rst(bram_rst),
        .bram_doa(bram_doa), .bram_dob(bram_dob),
        .busy(busy), .done(done)
    );

    function automatic logic [7:0] tbl(input int a);
        case (a)
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'hFA;
            3:       return 8'h06;
            default: return 8'(a) ^ 8'hA5;
        endcase
    endfunction

    // BRAM: address latch then output register, both gated by bram_en.
    always @(posedge clk) begin
        if (bram_rst) begin
            lat_a <= '0; lat_b <= '0; bram_doa <= '0; bram_dob <= '0;
        end else if (bram_en) begin
            lat_a <= bram_addra; lat_b <= bram_addrb;
            bram_doa <= tbl(int'(lat_a)); bram_dob <= tbl(int'(lat_b));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_addr_a = '0; req_addr_b = '0; req_tag = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start_batch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
        req_addr_a = '0; req_addr_b = '0; req_tag = '0;
        tick(); tick();
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%0b exp=0", done); end
        n_cmp++; if (bram_rst !== 1'b1) begin n_fail++; $display("FAIL rst_bram_rst got=%0b exp=1", bram_rst); end
        n_cmp++; if (bram_doa !== 8'h00) begin n_fail++; $display("FAIL rst_bram_doa got=%0h exp=0", bram_doa); end
        rst = 1'b0; start = 1'b0; req_valid = 1'b0;
        #1;
        n_cmp++; if (bram_rst !== 1'b0) begin n_fail++; $display("FAIL rst_bram_rst_release got=%0b exp=0", bram_rst); end
    endtask

    task automatic test_single();
        do_reset();
        start_batch();
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%0b exp=1", busy); end
        req_valid = 1'b1; req_addr_a = 10'h002; req_addr_b = 10'h003; req_tag = 4'd5;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL single_req_ready got=%0b exp=1", req_ready); end
        n_cmp++; if (bram_addra !== 10'h002 || bram_addrb !== 10'h003) begin n_fail++; $display("FAIL single_bram_addr got=%0h/%0h exp=2/3", bram_addra, bram_addrb); end
        tick();
        req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0; req_tag = '0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_early got=%0b exp=0", rsp_valid); end
        tick();
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
        n_cmp++; if (rsp_doa !== 8'hFA) begin n_fail++; $display("FAIL single_doa got=%0h exp=fa", rsp_doa); end
        n_cmp++; if (rsp_dob !== 8'h06) begin n_fail++; $display("FAIL single_dob got=%0h exp=06", rsp_dob); end
        n_cmp++; if (rsp_tag !== 4'd5) begin n_fail++; $display("FAIL single_tag got=%0d exp=5", rsp_tag); end
        tick();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_once got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic exp_b;
        do_reset();
        start_batch();
        for (int i = 0; i < 20; i++) begin
            req_valid = (i < 16);
            req_addr_a = ADDR_W'(i % 4); req_addr_b = ADDR_W'((i + 1) % 4); req_tag = TAG_W'(i);
            #1;
            exp_b = (i < 16);
            n_cmp++; if (req_ready !== exp_b) begin n_fail++; $display("FAIL b2b_req_ready[%0d] got=%0b exp=%0b", i, req_ready, exp_b); end
            if (i >= 2 && i < 18) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== TAG_W'(i - 2)) begin n_fail++; $display("FAIL b2b_rsp[%0d] got v=%0b tag=%0d exp v=1 tag=%0d", i, rsp_valid, rsp_tag, i - 2); end
                n_cmp++; if (rsp_doa !== tbl((i - 2) % 4) || rsp_dob !== tbl((i - 1) % 4)) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0h/%0h exp=%0h/%0h", i, rsp_doa, rsp_dob, tbl((i - 2) % 4), tbl((i - 1) % 4)); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_idle[%0d] got=%0b exp=0", i, rsp_valid); end
            end
            exp_b = (i == 18);
            n_cmp++; if (done !== exp_b) begin n_fail++; $display("FAIL b2b_done[%0d] got=%0b exp=%0b", i, done, exp_b); end
            tick();
        end
        req_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_stall();
        do_reset();
        start_batch();
        for (int i = 0; i < 11; i++) begin
            req_valid = (i < 8);
            req_tag   = (i < 3) ? TAG_W'(i) : TAG_W'(3);
            req_addr_a = ADDR_W'(int'(req_tag) % 4); req_addr_b = ADDR_W'(3 - int'(req_tag) % 4);
            rsp_ready = !(i >= 3 && i <= 6);
            #1;
            if (i >= 3 && i <= 6) begin
                n_cmp++; if (bram_en !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ctrl[%0d] got en=%0b rr=%0b exp 0/0", i, bram_en, req_ready); end
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1 || rsp_doa !== 8'h01 || rsp_dob !== 8'hFA) begin n_fail++; $display("FAIL stall_hold[%0d] got v=%0b tag=%0d d=%0h/%0h exp v=1 tag=1 d=01/fa", i, rsp_valid, rsp_tag, rsp_doa, rsp_dob); end
            end else if (i >= 2 && i <= 9) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== TAG_W'(i == 2 ? 0 : i - 6)) begin n_fail++; $display("FAIL stall_rsp[%0d] got v=%0b tag=%0d exp v=1 tag=%0d", i, rsp_valid, rsp_tag, (i == 2 ? 0 : i - 6)); end
                n_cmp++; if (rsp_doa !== tbl(int'(rsp_tag) % 4) || rsp_dob !== tbl(3 - int'(rsp_tag) % 4)) begin n_fail++; $display("FAIL stall_data[%0d] got=%0h/%0h exp=%0h/%0h", i, rsp_doa, rsp_dob, tbl(int'(rsp_tag) % 4), tbl(3 - int'(rsp_tag) % 4)); end
            end else begin
                n_cmp++; if (rsp_valid !== (i == 2)) begin n_fail++; $display("FAIL stall_rsp_none[%0d] got=%0b exp=0", i, rsp_valid); end
            end
            tick();
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        start_batch();
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_tag = TAG_W'(i); req_addr_a = ADDR_W'(i); req_addr_b = ADDR_W'(i);
            tick();
        end
        req_valid = 1'b0; rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_during got v=%0b busy=%0b exp 0/0", rsp_valid, busy); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_after[%0d] got v=%0b busy=%0b done=%0b exp 0/0/0", i, rsp_valid, busy, done); end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        do_reset();
        start_batch();
        for (int i = 0; i < 17; i++) begin
            req_valid = (i < 16); req_tag = TAG_W'(i); req_addr_a = '0; req_addr_b = '0;
            start = (i == 1);
            #1;
            if (i == 16) begin
                n_cmp++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL start_ignored_cnt got rr=%0b busy=%0b exp 0/1", req_ready, busy); end
            end
            tick();
        end
        start = 1'b0; req_valid = 1'b0;
        do_reset();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL start_with_rst got busy=%0b rr=%0b exp 0/0", busy, req_ready); end
        tick();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_with_rst_late got busy=%0b exp 0", busy); end
    endtask

    task automatic test_idle_drain();
        do_reset();
        req_valid = 1'b1; req_addr_a = 10'h002; req_addr_b = 10'h002; req_tag = 4'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req[%0d] got rr=%0b v=%0b exp 0/0", i, req_ready, rsp_valid); end
            tick();
        end
        start_batch();
        for (int i = 0; i < 20; i++) begin
            req_tag = TAG_W'(i);
            #1;
            if (i >= 16 && i < 18) begin
                n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_req_ready[%0d] got=%0b exp=0", i, req_ready); end
            end
            if (i >= 18) begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_no_rsp[%0d] got=%0b exp=0", i, rsp_valid); end
            end
            if (i == 18) begin
                n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL drain_done got=%0b exp=1", done); end
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_start_ignored();
        test_idle_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
